lock_keypad_sequencer: RTL

//  Keypad-side initiator for the six-digit lock controller. Collects BCD key presses one digit at a time,

---
 rtl/lock_keypad_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lock_keypad_sequencer.sv
// Keypad-side initiator for the six-digit lock controller: collects BCD digits,
// streams them as three pairs to the controller, judges the result and enforces lockout.
module lock_keypad_sequencer #(
  parameter int HOLD        = 2,
  parameter int JUDGE_WAIT  = 2,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_clear,
  input  logic       mode_set,
  input  logic       res_in,
  output logic [3:0] lock_in_a,
  output logic [3:0] lock_in_b,
  output logic       lock_a0,
  output logic       lock_a1,
  output logic       lock_m,
  output logic       lock_clr,
  output logic       busy,
  output logic [2:0] digit_cnt,
  output logic       unlock,
  output logic       fail,
  output logic       prog_done,
  output logic       locked_out,
  output logic [2:0] fail_cnt
);

  localparam int TMAX_A = (HOLD > JUDGE_WAIT) ? HOLD : JUDGE_WAIT;
  localparam int TMAX   = (TMAX_A > LOCK_CYCLES) ? TMAX_A : LOCK_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);
  localparam logic [2:0] MAX_F = 3'(MAX_FAIL);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_SEND1, S_SEND2, S_SEND3, S_JUDGE, S_RESULT, S_DONE, S_LOCKOUT
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [5:0][3:0] digits_q;
  logic            mode_q;
  logic [2:0]      digit_cnt_q;
  logic [2:0]      fail_cnt_q;
  logic [3:0]      in_a_q, in_b_q;
  logic [1:0]      sel_q;
  logic            lock_m_q, lock_clr_q, busy_q;
  logic            unlock_q, fail_q, prog_done_q, locked_out_q;

  // Outputs are set on the edge that enters each state, so every bus value
  // and pulse is a flop output aligned with the state it belongs to.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      digits_q     <= '0;
      mode_q       <= 1'b0;
      digit_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      in_a_q       <= '0;
      in_b_q       <= '0;
      sel_q        <= 2'b11;
      lock_m_q     <= 1'b1;
      lock_clr_q   <= 1'b0;
      busy_q       <= 1'b0;
      unlock_q     <= 1'b0;
      fail_q       <= 1'b0;
      prog_done_q  <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      lock_clr_q  <= 1'b0;
      unlock_q    <= 1'b0;
      fail_q      <= 1'b0;
      prog_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_clear) begin
            digit_cnt_q <= '0;
            mode_q      <= 1'b0;
          end else if (key_valid && key_digit <= 4'd9) begin
            digits_q[digit_cnt_q] <= key_digit;
            digit_cnt_q           <= digit_cnt_q + 3'd1;
            if (digit_cnt_q == 3'd0) mode_q <= mode_set;
            if (digit_cnt_q == 3'd5) begin
              state_q    <= S_CLR;
              busy_q     <= 1'b1;
              lock_clr_q <= 1'b1;
              lock_m_q   <= ~mode_q;
            end
          end
        end
        S_CLR: begin
          state_q <= S_SEND1;
          timer_q <= TW'(HOLD - 1);
          sel_q   <= 2'b00;
          in_a_q  <= digits_q[0];
          in_b_q  <= digits_q[1];
        end
        S_SEND1, S_SEND2: begin
          if (timer_q == '0) begin
            timer_q <= TW'(HOLD - 1);
            if (state_q == S_SEND1) begin
              state_q <= S_SEND2;
              sel_q   <= 2'b01;
              in_a_q  <= digits_q[2];
              in_b_q  <= digits_q[3];
            end else begin
              state_q <= S_SEND3;
              sel_q   <= 2'b10;
              in_a_q  <= digits_q[4];
              in_b_q  <= digits_q[5];
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_SEND3: begin
          if (timer_q == '0) begin
            sel_q    <= 2'b11;
            lock_m_q <= 1'b1;
            in_a_q   <= '0;
            in_b_q   <= '0;
            if (mode_q) begin
              state_q     <= S_DONE;
              prog_done_q <= 1'b1;
            end else begin
              state_q <= S_JUDGE;
              timer_q <= TW'(JUDGE_WAIT - 1);
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_JUDGE: begin
          if (timer_q == '0) begin
            state_q <= S_RESULT;
            if (res_in) begin
              unlock_q   <= 1'b1;
              fail_cnt_q <= '0;
            end else begin
              fail_q <= 1'b1;
              if (fail_cnt_q < MAX_F) fail_cnt_q <= fail_cnt_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_RESULT: begin
          digit_cnt_q <= '0;
          // fail_cnt only reaches MAX_FAIL through a mismatch, so this implies a fail
          if (fail_cnt_q == MAX_F) begin
            state_q      <= S_LOCKOUT;
            locked_out_q <= 1'b1;
            timer_q      <= TW'(LOCK_CYCLES - 1);
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          digit_cnt_q <= '0;
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
        end
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            locked_out_q <= 1'b0;
            fail_cnt_q   <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lock_in_a  = in_a_q;
  assign lock_in_b  = in_b_q;
  assign lock_a0    = sel_q[0];
  assign lock_a1    = sel_q[1];
  assign lock_m     = lock_m_q;
  assign lock_clr   = lock_clr_q;
  assign busy       = busy_q;
  assign digit_cnt  = digit_cnt_q;
  assign unlock     = unlock_q;
  assign fail       = fail_q;
  assign prog_done  = prog_done_q;
  assign locked_out = locked_out_q;
  assign fail_cnt   = fail_cnt_q;

endmodule
